// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory (apb_slave_mem).
package apb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic SLVERR_RESP = 1'b1;
  localparam logic OKAY_RESP   = 1'b0;

  function automatic logic addr_out_of_range(input logic [31:0] addr, input int depth);
    return addr >= 32'(depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W register file: synchronous clear, one write port, combinational read port.
module apb_slave_regfile #(
  parameter int ADDR_W = apb_pkg::ADDR_W_DEF,
  parameter int DATA_W = apb_pkg::DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One flop row per implemented location; addresses beyond DEPTH never match.
  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
        mem[g] <= '0;
      end else if (we && (waddr == ADDR_W'(g))) begin
        mem[g] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a small register-file memory, registered outputs and
// optional wait-state insertion (macro APB_SLV_WAIT_EN enables the wait counter).
//
// state  | meaning
// IDLE   | waiting for Psel with Penable low; latches address/data/direction
// SETUP  | one cycle; loads the wait counter, raises Pready when no waits
// ACCESS | counts waits, then holds Pready until Penable completes or Psel aborts
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              Pclk,
  input  logic              Presetn,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] PWdata,
  output logic [DATA_W-1:0] PRdata,
  output logic              Pready,
  output logic              Pslverr
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("apb_slave_mem: DEPTH out of range");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_slave_mem: WAIT_STATES out of range");
  end

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              ready_q, ready_d;
  logic              slverr_q, slverr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              addr_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] resp_data;
  logic              wait_zero_load;
  logic              wait_done;

  apb_slave_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk_sys (Pclk),
    .rst_b   (Presetn),
    .we      (mem_we),
    .waddr   (addr_q),
    .wdata   (wdata_q),
    .raddr   (addr_q),
    .rdata   (mem_rdata)
  );

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [3:0] cnt_q, cnt_d;

  // Pready is raised on the edge that takes the counter from 1 to 0.
  assign wait_zero_load = (WAIT_LOAD == 4'd0);
  assign wait_done      = (cnt_q <= 4'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = WAIT_LOAD;
    end else if (state_q == ACCESS && Psel && !ready_q && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Presetn) cnt_q <= 4'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign wait_zero_load = 1'b1;
  assign wait_done      = 1'b1;
`endif

  assign addr_err  = addr_out_of_range(32'(addr_q), DEPTH);
  // Writes and erroring reads return zero on PRdata.
  assign resp_data = (write_q || addr_err) ? '0 : mem_rdata;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Psel && !Penable) begin
          addr_d  = Paddr;
          wdata_d = PWdata;
          write_d = Pwrite;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (wait_zero_load) begin
          ready_d  = 1'b1;
          slverr_d = addr_err ? SLVERR_RESP : OKAY_RESP;
          rdata_d  = resp_data;
        end
        state_d = ACCESS;
      end

      ACCESS: begin
        if (!Psel) begin
          ready_d  = 1'b0;
          slverr_d = OKAY_RESP;
          rdata_d  = '0;
          state_d  = IDLE;
        end else if (ready_q) begin
          if (Penable) begin
            mem_we   = write_q && !addr_err;
            ready_d  = 1'b0;
            slverr_d = OKAY_RESP;
            rdata_d  = '0;
            state_d  = IDLE;
          end
        end else if (wait_done) begin
          ready_d  = 1'b1;
          slverr_d = addr_err ? SLVERR_RESP : OKAY_RESP;
          rdata_d  = resp_data;
        end
      end

      default: begin
        ready_d  = 1'b0;
        slverr_d = OKAY_RESP;
        rdata_d  = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= OKAY_RESP;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign PRdata  = rdata_q;
  assign Pready  = ready_q;
  assign Pslverr = slverr_q;

endmodule
